serial_borrow_sub: RTL and testbench

//   Bit-serial ripple-borrow subtractor: D = A - B - Bin.

---
 rtl/serial_borrow_sub.sv | 114 +++++++++++
 tb/tb_serial_borrow_sub.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_sub.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell and one borrow flop.
module serial_borrow_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o,
  output logic             v_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic             a_bit, b_bit, diff_bit, br_next, last_bit;

  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          br_d    = bin_i;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        d_d    = {diff_bit, d_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        if (last_bit) begin
          // Overflow: borrow into the MSB cell differs from the borrow out of it.
          state_d = ST_DONE;
          bout_d  = br_next;
          v_d     = br_next ^ br_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign d_o    = d_q;
  assign bout_o = bout_q;
  assign v_o    = v_q;

endmodule

// File: tb/tb_serial_borrow_sub.sv
// Scoreboard bench for serial_borrow_sub: expected results are queued at issue
// and a negedge monitor compares them whenever DONE is presented.
module tb_serial_borrow_sub;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int NSWP  = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done;
  logic [WIDTH-1:0] d;
  logic             bout, v;

  serial_borrow_sub #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (done),
    .d_o    (d),
    .bout_o (bout),
    .v_o    (v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int bout;
    int v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   sweep_mode = 1'b0;
  int   last_done = -1;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int av, input int bv, input int bi);
    exp_t e;
    int   du, sa, sbv, ds;
    du     = av - bv - bi;
    e.d    = du & MASK;
    e.bout = (du < 0) ? 1 : 0;
    sa     = (av >= (1 << (WIDTH - 1))) ? av - (1 << WIDTH) : av;
    sbv    = (bv >= (1 << (WIDTH - 1))) ? bv - (1 << WIDTH) : bv;
    ds     = sa - sbv - bi;
    e.v    = (ds > (1 << (WIDTH - 1)) - 1 || ds < -(1 << (WIDTH - 1))) ? 1 : 0;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_pulse_width", int'(prev_done), 0);
      chk("busy_with_done", int'(busy), 1);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("D", int'(d), e.d);
        chk("Bout", int'(bout), e.bout);
        chk("V", int'(v), e.v);
        $display("op done: D=%0h Bout=%0d V=%0d (expected %0h %0d %0d)", d, bout, v, e.d, e.bout, e.v);
      end
      if (sweep_mode && last_done >= 0) chk("period", cyc - last_done, WIDTH + 2);
      last_done = cyc;
    end
    prev_done = done;
  end

  // One operation from IDLE; optionally fires a START with all-ones operands mid-RUN.
  task automatic run_op(input int av, input int bv, input int bi, input bit inject);
    int   acc, k;
    exp_t e;
    @(negedge clk);
    a = WIDTH'(av); b = WIDTH'(bv); bin = bi[0]; start = 1'b1;
    e = model(av, bv, bi);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    chk("busy_after_accept", int'(busy), 1);
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    k = 0;
    while (!done && k < 4 * WIDTH) begin
      @(negedge clk);
      k++;
      if (inject && k == 1) begin
        start = 1'b1; a = WIDTH'(MASK); b = WIDTH'(MASK);
      end else if (inject && k == 2) begin
        start = 1'b0;
      end
    end
    if (!done) chk("done_timeout", int'(done), 1);
    else chk("latency", cyc - acc, WIDTH);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("hold_D", int'(d), e.d);
    chk("hold_Bout", int'(bout), e.bout);
    chk("hold_V", int'(v), e.v);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_D", int'(d), 0);
    chk("rst_Bout", int'(bout), 0);
    chk("rst_V", int'(v), 0);

    run_op(9, 3, 0, 1'b0);
    run_op(3, 9, 0, 1'b0);
    run_op(0, 0, 1, 1'b0);
    run_op(8, 1, 0, 1'b0);
    run_op(6, 2, 1, 1'b1);   // START with F/F during RUN must be ignored
    run_op(8, 1, 0, 1'b0);   // leave non-zero results before the abort

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_D", int'(d), 0);
    chk("abort_Bout", int'(bout), 0);
    chk("abort_V", int'(v), 0);
    repeat (3 * WIDTH) @(negedge clk);
    chk("abort_still_idle", int'(busy), 0);
    run_op(12, 5, 1, 1'b0);

    // Reset and START together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 4'd7; b = 4'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", int'(busy), 0);

    repeat (30) run_op(int'($urandom_range(MASK)), int'($urandom_range(MASK)),
                       int'($urandom_range(1)), 1'b0);

    // Exhaustive sweep with START held high; each DONE cycle loads the next operands.
    sweep_mode = 1'b1;
    last_done  = -1;
    @(negedge clk);
    a = '0; b = '0; bin = 1'b0; start = 1'b1;
    sb_q.push_back(model(0, 0, 0));
    for (int i = 1; i <= NSWP; i++) begin
      k = 0;
      @(negedge clk);
      while (!done && k < 4 * WIDTH) begin
        @(negedge clk);
        k++;
      end
      if (!done) begin
        chk("sweep_timeout", int'(done), 1);
        break;
      end
      if (i < NSWP) begin
        a = WIDTH'(i & MASK); b = WIDTH'((i >> WIDTH) & MASK); bin = 1'((i >> (2 * WIDTH)) & 1);
        sb_q.push_back(model(i & MASK, (i >> WIDTH) & MASK, (i >> (2 * WIDTH)) & 1));
      end else begin
        start = 1'b0;
      end
    end
    repeat (2 * WIDTH) @(negedge clk);
    sweep_mode = 1'b0;
    chk("sweep_end_idle", int'(busy), 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
